// File: rtl/core_pkg.sv
// Shared RV32I-subset definitions: ALU op codes, opcodes, sequencer states and
// instruction classes. Used by the sequencer, the ALU and the single-cycle decoder.
package core_pkg;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluXor  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluAnd  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsR      = 3'd0,
    ClsI      = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4
  } instr_class_e;

  // Decode of the {funct7, funct3} key; anything unrecognised falls back to ADD.
  function automatic logic [3:0] r_alu_op(input logic [9:0] key);
    case (key)
      10'b0000000_000: return AluAdd;
      10'b0100000_000: return AluSub;
      10'b0000000_100: return AluXor;
      10'b0000000_110: return AluOr;
      10'b0000000_111: return AluAnd;
      10'b0000000_001: return AluSll;
      10'b0000000_101: return AluSrl;
      10'b0100000_101: return AluSra;
      10'b0000000_010: return AluSlt;
      10'b0000000_011: return AluSltu;
      default:         return AluAdd;
    endcase
  endfunction

  // Immediate forms: instr[31:25] is immediate data except for the shifts.
  function automatic logic [3:0] i_alu_op(input logic [6:0] funct7, input logic [2:0] funct3);
    case (funct3)
      3'b000:  return AluAdd;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b110:  return AluOr;
      3'b111:  return AluAnd;
      default: return r_alu_op({funct7, funct3});
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port: request/ready handshake plus the
// write strobe and address-source select that travel with the request.
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/instr_classifier.sv
// Combinational instruction classifier: opcode to class, ALU operation and an
// illegal flag for opcodes and branch forms the core does not implement.
module instr_classifier
  import core_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e cls,
  output logic [3:0]   alu_op,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    cls     = ClsR;
    alu_op  = AluAdd;
    illegal = 1'b0;
    unique case (opcode)
      OpcR: begin
        cls    = ClsR;
        alu_op = r_alu_op({funct7, funct3});
      end
      OpcI: begin
        cls    = ClsI;
        alu_op = i_alu_op(funct7, funct3);
      end
      OpcLoad:  cls = ClsLoad;
      OpcStore: cls = ClsStore;
      OpcBranch: begin
        cls     = ClsBranch;
        alu_op  = AluSub;
        // Only BEQ (000) and BNE (001) are supported.
        illegal = (funct3[2:1] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH..WRITEBACK,
// drives datapath enables and the shared memory port, and counts cycles/retires.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        instr,
  input  logic                   alu_zero,
  multicycle_sequencer_if.master mem,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   pc_sel_branch,
  output logic                   rf_we,
  output logic                   wb_sel_mem,
  output logic                   alu_src_imm,
  output logic [3:0]             alu_op,
  output logic [2:0]             state,
  output logic                   illegal,
  output logic [XLEN-1:0]        cycle_cnt,
  output logic [XLEN-1:0]        instret_cnt
);

  state_e          state_q, state_d;
  instr_class_e    cls_q, dec_cls;
  logic [3:0]      alu_op_q, dec_alu_op;
  logic            bne_q;
  logic            dec_illegal;
  logic            retire;
  logic            branch_taken;
  logic [XLEN-1:0] cycle_q, instret_q;

  instr_classifier u_classifier (
    .instr   (instr[31:0]),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign branch_taken = bne_q ? ~alu_zero : alu_zero;

  always_comb begin
    state_d       = state_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    rf_we         = 1'b0;
    wb_sel_mem    = 1'b0;
    alu_src_imm   = 1'b0;
    retire        = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = dec_illegal ? StTrap : StExecute;
      StExecute: begin
        alu_src_imm = (cls_q == ClsI) || (cls_q == ClsLoad) || (cls_q == ClsStore);
        case (cls_q)
          ClsR, ClsI:        state_d = StWriteback;
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch: begin
            pc_we         = branch_taken;
            pc_sel_branch = branch_taken;
            retire        = 1'b1;
            state_d       = StFetch;
          end
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (cls_q == ClsStore);
        alu_src_imm  = 1'b1;
        if (mem.mem_ready) begin
          retire  = (cls_q == ClsStore);
          state_d = (cls_q == ClsStore) ? StFetch : StWriteback;
        end
      end
      StWriteback: begin
        rf_we      = 1'b1;
        wb_sel_mem = (cls_q == ClsLoad);
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      alu_op_q  <= AluAdd;
      bne_q     <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + XLEN'(1);
      if (retire) instret_q <= instret_q + XLEN'(1);
      if (state_q == StDecode) begin
        cls_q    <= dec_cls;
        alu_op_q <= dec_alu_op;
        bne_q    <= instr[12];
      end
    end
  end

  assign alu_op      = alu_op_q;
  assign state       = state_q;
  assign illegal     = (state_q == StTrap);
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I-subset core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the datapath enables, the ALU operation and a shared instruction/data memory port through a req/ready handshake. It replaces the single-cycle decoder wherever the core shares one memory port. It also keeps cycle and retired-instruction counters for the testbench and for debug.

## Interface
- `XLEN`, default 32: width of the instruction input and of the counters.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `instr`  in  32: instruction register output from the datapath; valid from DECODE onward.
- `mem_ready`  in  1: memory completes the current request on this edge.
- `alu_zero`  in  1: ALU result == 0; sampled in EXECUTE only.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: request is a write (store).
- `addr_sel`  out  1: memory address source, 0 = PC, 1 = ALU result.
- `ir_we`, `pc_we`  out  1 each: IR and PC load enables.
- `pc_sel_branch`  out  1: PC source, 0 = PC+4, 1 = branch target.
- `rf_we`  out  1: register-file write.
- `wb_sel_mem`  out  1: write-back data source, 0 = ALU, 1 = memory.
- `alu_src_imm`  out  1: ALU operand B source, 0 = rs2, 1 = immediate.
- `alu_op`  out  4: ALU operation.
- `state`  out  3: current state, for debug.
- `illegal`  out  1: sticky trap flag.
- `cycle_cnt`, `instret_cnt`  out  XLEN each: cycle counter and retired-instruction counter.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Codes 6–7 go to FETCH.
- **FETCH:** `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1: `ir_we`=1 and `pc_we`=1 with `pc_sel_branch`=0, both combinational on ready. Next state is DECODE.
- **DECODE:** classifies `instr[6:0]` into a registered class: R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011).
  - Registers `alu_op` from `{instr[31:25], instr[14:12]}`: ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9.
  - Unrecognised funct fields give ADD.
  - LOAD, STORE and BRANCH force ADD, ADD and SUB respectively.
  - Any other opcode, or BRANCH with funct3 not 000 (BEQ) or 001 (BNE), goes to TRAP.
  - Otherwise next state is EXECUTE.
- **EXECUTE:** `alu_src_imm`=1 for I, LOAD and STORE.
  - R and I go to WRITEBACK; LOAD and STORE go to MEM.
  - BRANCH: taken = `alu_zero` for BEQ, ~`alu_zero` for BNE. If taken, `pc_we`=1 and `pc_sel_branch`=1 (combinational). Retires; next state is FETCH.
  - The datapath computes the branch target from the old PC it holds.
- **MEM:** `mem_req`=1, `addr_sel`=1, `alu_src_imm`=1, `mem_we`=1 for STORE.
  - Waits for `mem_ready`. On ready, LOAD goes to WRITEBACK; STORE retires and goes to FETCH.
- **WRITEBACK:** `rf_we`=1 and `wb_sel_mem`=1 for LOAD. Retires; next state is FETCH.
- **TRAP:** all enables 0 and `illegal`=1. Leaves only on `rst`.
- **Counters:**
  - `cycle_cnt` increments every non-reset cycle.
  - `instret_cnt` increments on each retiring edge.
  - Both wrap modulo 2^XLEN.

## Timing
- Reset values: state=FETCH; `illegal`=0; counters=0; `alu_op`=0; class=R; all enables and selects 0 except `mem_req`=1, since FETCH requests in the first cycle after reset.
- `rst` asserted mid-instruction, including during a pending MEM write:
  - Abort at that edge; the write is not completed by the sequencer.
  - All state returns to reset values.
  - `rst` has priority over every transition.
- Memory handshake:
  - The transfer completes on an edge where `mem_req` and `mem_ready` are both 1.
  - Address and controls hold stable while `mem_req`=1.
  - `mem_ready` is ignored when `mem_req`=0.
  - `mem_req` never deasserts before completion except on `rst`.
- Output timing: outputs are Moore from state plus registered class and `alu_op`. The exceptions are `ir_we` and `pc_we` in FETCH and `pc_we`/`pc_sel_branch` in EXECUTE, which are Mealy.
- Latency with zero wait states: R/I = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3. Each memory wait cycle adds 1.

## Structure
- Package `core_pkg`:
  - ALU op localparams, shared with the ALU and the single-cycle decoder.
  - Opcode constants.
  - State enum encoding.
  - Instruction class encoding.
- Sub-module `instr_classifier`: combinational. Maps `instr` to class, `alu_op` and illegal. Instantiated once and registered in DECODE.

## Test plan
- **ADD:** `instr`=0x002081B3 (add x3,x1,x2), `mem_ready`=1 → states 0,1,2,4,0; `alu_op`=0; `rf_we`=1 only in cycle 4; `instret_cnt`=1 after 4 cycles.
- **Load with wait states:** 0x0000A183 (lw x3,0(x1)), `mem_ready` low 3 cycles in MEM → MEM lasts 4 cycles; `addr_sel`=1; `mem_we`=0; WRITEBACK has `wb_sel_mem`=1; 8 cycles total.
- **Store:** 0x0020A023 (sw x2,0(x1)) → `mem_we`=1 only in MEM; `rf_we` never asserts; back to FETCH after 4 cycles.
- **Branch:** 0x00000463 (beq x0,x0,8) with `alu_zero`=1 → `alu_op`=1; `pc_we`=`pc_sel_branch`=1 in EXECUTE. Repeat with `alu_zero`=0 → no `pc_we` in EXECUTE.
- **Illegal opcode:** 0x0000007F → TRAP after DECODE; `illegal`=1 held 20 cycles; `instret_cnt` unchanged; `rst` → FETCH with `illegal`=0.
- **Reset during MEM:** `rst` pulse during MEM of a store with `mem_ready`=0 → next cycle state=0; counters=0; `mem_we`=0.
